// File: rtl/mastermind_pkg.sv
// Shared sizing, shape codes and controller states for the Mastermind game controller.
package mastermind_pkg;
    localparam int NUM_SLOTS  = 4;
    localparam int SHAPE_W    = 3;
    localparam int MAX_ROUNDS = 8;
    localparam int PATTERN_W  = NUM_SLOTS * SHAPE_W;
    localparam int SLOT_W     = $clog2(NUM_SLOTS);
    localparam int ROUND_W    = 4;
    localparam int EXACT_W    = 3;

    typedef enum logic [SHAPE_W-1:0] {
        SHAPE_NONE = 3'd0,
        SHAPE_1    = 3'd1,
        SHAPE_2    = 3'd2,
        SHAPE_3    = 3'd3,
        SHAPE_4    = 3'd4,
        SHAPE_5    = 3'd5,
        SHAPE_6    = 3'd6,
        SHAPE_7    = 3'd7
    } shape_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PLAY  = 3'd2,
        GRADE = 3'd3,
        DONE  = 3'd4
    } ctrl_state_t;

    function automatic logic [ROUND_W-1:0] round_sat_inc(input logic [ROUND_W-1:0] round);
        logic [ROUND_W-1:0] result;
        if (round >= ROUND_W'(MAX_ROUNDS)) begin
            result = ROUND_W'(MAX_ROUNDS);
        end else begin
            result = round + ROUND_W'(1);
        end
        return result;
    endfunction
endpackage

// File: rtl/mastermind_game_ctrl_if.sv
// User-input / grader bundle of the game controller; master drives inputs, slave is the controller.
interface mastermind_game_ctrl_if;
    import mastermind_pkg::*;

    logic                 startGame;
    logic                 loadingShape;
    logic [SHAPE_W-1:0]   LoadShape;
    logic [SLOT_W-1:0]    ShapeLocation;
    logic                 gradeIt;
    logic [PATTERN_W-1:0] Guess;
    logic                 gradeAck;
    logic [EXACT_W-1:0]   numExact;
    logic [PATTERN_W-1:0] masterPattern;
    logic                 masterLoaded;
    logic                 gradeReq;
    logic [PATTERN_W-1:0] guessOut;
    logic [ROUND_W-1:0]   roundNumber;
    logic                 gameOver;
    logic                 gameWon;
    logic                 loadError;

    modport master (
        output startGame, loadingShape, LoadShape, ShapeLocation, gradeIt, Guess, gradeAck, numExact,
        input  masterPattern, masterLoaded, gradeReq, guessOut, roundNumber, gameOver, gameWon, loadError
    );

    modport slave (
        input  startGame, loadingShape, LoadShape, ShapeLocation, gradeIt, Guess, gradeAck, numExact,
        output masterPattern, masterLoaded, gradeReq, guessOut, roundNumber, gameOver, gameWon, loadError
    );
endinterface

// File: rtl/master_pattern_bank.sv
// Master-pattern register bank: slot storage, valid bitmap and load accept/reject.
// Build option: define LOAD_OVERWRITE_EN to let a non-zero load replace an occupied slot.
module master_pattern_bank
    import mastermind_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_L,
    input  logic                 clear,
    input  logic                 load_en,
    input  logic [SHAPE_W-1:0]   load_shape,
    input  logic [SLOT_W-1:0]    load_slot,
    output logic [PATTERN_W-1:0] pattern,
    output logic                 load_error,
    output logic                 full_next
);
    logic [NUM_SLOTS-1:0][SHAPE_W-1:0] pattern_r;
    logic [NUM_SLOTS-1:0]              valid_r;
    logic                              load_error_r;
    logic [NUM_SLOTS-1:0]              slot_bit_s;
    logic                              accept_s;
    logic                              reject_s;

    // Decide whether the presented load is accepted, rejected or absent.
    always_comb begin
        slot_bit_s = NUM_SLOTS'(1'b1) << load_slot;
        accept_s   = 1'b0;
        reject_s   = 1'b0;
        if (load_en) begin
            if (load_shape == SHAPE_NONE) begin
                reject_s = 1'b1;
`ifdef LOAD_OVERWRITE_EN
            end else begin
                accept_s = 1'b1;
            end
`else
            end else if ((valid_r & slot_bit_s) != {NUM_SLOTS{1'b0}}) begin
                reject_s = 1'b1;
            end else begin
                accept_s = 1'b1;
            end
`endif
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
    end

    // Lets the controller leave LOAD on the same edge that fills the last slot.
    assign full_next = &(valid_r | (accept_s ? slot_bit_s : {NUM_SLOTS{1'b0}}));

    // Slot storage, valid bitmap and the one-cycle reject pulse.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            pattern_r    <= {PATTERN_W{1'b0}};
            valid_r      <= {NUM_SLOTS{1'b0}};
            load_error_r <= 1'b0;
        end else if (clear) begin
            pattern_r    <= {PATTERN_W{1'b0}};
            valid_r      <= {NUM_SLOTS{1'b0}};
            load_error_r <= 1'b0;
        end else begin
            load_error_r <= reject_s;
            if (accept_s) begin
                pattern_r[load_slot] <= load_shape;
                valid_r              <= valid_r | slot_bit_s;
            end
        end
    end

    assign pattern    = pattern_r;
    assign load_error = load_error_r;
endmodule

// File: rtl/mastermind_game_ctrl.sv
// Game sequencer: pattern load, guess/grade handshake, round counting and win/lose detection.
// Build option LOAD_OVERWRITE_EN is handled inside master_pattern_bank.
module mastermind_game_ctrl
    import mastermind_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_L,
    mastermind_game_ctrl_if.slave bus
);
    ctrl_state_t          state_r;
    logic                 grade_req_r;
    logic [PATTERN_W-1:0] guess_r;
    logic [ROUND_W-1:0]   round_r;
    logic                 game_over_r;
    logic                 game_won_r;
    logic                 master_loaded_r;
    logic                 bank_clear_s;
    logic                 bank_load_en_s;
    logic                 bank_full_next_s;
    logic [ROUND_W-1:0]   next_round_s;

    // Gate bank controls by state: loads only in LOAD, clears only on a game start.
    always_comb begin
        bank_clear_s   = 1'b0;
        bank_load_en_s = 1'b0;
        if (state_r == LOAD) begin
            bank_load_en_s = bus.loadingShape;
        end else begin
            bank_load_en_s = 1'b0;
        end
        if ((state_r == IDLE || state_r == DONE) && bus.startGame) begin
            bank_clear_s = 1'b1;
        end else begin
            bank_clear_s = 1'b0;
        end
    end

    assign next_round_s = round_sat_inc(round_r);

    master_pattern_bank u_bank (
        .clock      (clock),
        .reset_L    (reset_L),
        .clear      (bank_clear_s),
        .load_en    (bank_load_en_s),
        .load_shape (bus.LoadShape),
        .load_slot  (bus.ShapeLocation),
        .pattern    (bus.masterPattern),
        .load_error (bus.loadError),
        .full_next  (bank_full_next_s)
    );

    // Controller FSM with all status outputs registered.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_r         <= IDLE;
            grade_req_r     <= 1'b0;
            guess_r         <= {PATTERN_W{1'b0}};
            round_r         <= {ROUND_W{1'b0}};
            game_over_r     <= 1'b0;
            game_won_r      <= 1'b0;
            master_loaded_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (bus.startGame) begin
                        state_r         <= LOAD;
                        round_r         <= {ROUND_W{1'b0}};
                        game_over_r     <= 1'b0;
                        game_won_r      <= 1'b0;
                        master_loaded_r <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bank_full_next_s) begin
                        master_loaded_r <= 1'b1;
                        state_r         <= PLAY;
                    end
                end
                PLAY: begin
                    if (bus.gradeIt) begin
                        guess_r     <= bus.Guess;
                        grade_req_r <= 1'b1;
                        state_r     <= GRADE;
                    end
                end
                GRADE: begin
                    if (bus.gradeAck) begin
                        grade_req_r <= 1'b0;
                        round_r     <= next_round_s;
                        if (bus.numExact == EXACT_W'(NUM_SLOTS)) begin
                            game_won_r  <= 1'b1;
                            game_over_r <= 1'b1;
                            state_r     <= DONE;
                        end else if (next_round_s == ROUND_W'(MAX_ROUNDS)) begin
                            game_won_r  <= 1'b0;
                            game_over_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            state_r <= PLAY;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    grade_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gradeReq     = grade_req_r;
    assign bus.guessOut     = guess_r;
    assign bus.roundNumber  = round_r;
    assign bus.gameOver     = game_over_r;
    assign bus.gameWon      = game_won_r;
    assign bus.masterLoaded = master_loaded_r;
endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Self-checking bench for mastermind_game_ctrl: vector table, directed corner sequences, random play vs model.
module tb_mastermind_game_ctrl;
    import mastermind_pkg::*;

    logic clock = 1'b0;
    logic reset_L;
    int   total = 0;
    int   bad   = 0;

`ifdef LOAD_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif

    mastermind_game_ctrl_if bus();

    mastermind_game_ctrl dut (
        .clock   (clock),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Reference model: game described by what has happened so far, not by controller states.
    logic [2:0]  m_pat [4];
    logic [3:0]  m_fill;
    logic [11:0] m_guess;
    bit          m_loaded, m_over, m_won, m_pending, m_ingame, m_err;
    int          m_rounds;

    typedef struct packed {
        logic        st, ld;
        logic [2:0]  sh;
        logic [1:0]  sl;
        logic        gr;
        logic [11:0] gu;
        logic        ak;
        logic [2:0]  ex;
        logic [11:0] e_pat;
        logic        e_loaded, e_err, e_req;
        logic [3:0]  e_round;
        logic        e_over, e_won;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(logic st, logic ld, logic [2:0] sh, logic [1:0] sl, logic gr,
                                logic [11:0] gu, logic ak, logic [2:0] ex, logic [11:0] ep,
                                logic el, logic ee, logic eq, logic [3:0] er, logic eo, logic ew);
        vec_t v;
        v.st = st; v.ld = ld; v.sh = sh; v.sl = sl; v.gr = gr; v.gu = gu; v.ak = ak; v.ex = ex;
        v.e_pat = ep; v.e_loaded = el; v.e_err = ee; v.e_req = eq; v.e_round = er;
        v.e_over = eo; v.e_won = ew;
        return v;
    endfunction

    function automatic logic [11:0] m_pattern();
        return {m_pat[3], m_pat[2], m_pat[1], m_pat[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pat[i] = 3'd0;
        m_fill = 4'd0; m_guess = 12'd0; m_loaded = 0; m_over = 0; m_won = 0;
        m_pending = 0; m_ingame = 0; m_err = 0; m_rounds = 0;
    endtask

    task automatic model_update();
        m_err = 0;
        if (!m_ingame) begin
            if (bus.startGame) begin
                for (int i = 0; i < 4; i++) m_pat[i] = 3'd0;
                m_fill = 4'd0; m_loaded = 0; m_rounds = 0; m_over = 0; m_won = 0; m_ingame = 1;
            end
        end else if (!m_loaded) begin
            if (bus.loadingShape) begin
                if (bus.LoadShape == 3'd0) m_err = 1;
                else if (m_fill[bus.ShapeLocation] && !OVERWRITE) m_err = 1;
                else begin
                    m_pat[bus.ShapeLocation]  = bus.LoadShape;
                    m_fill[bus.ShapeLocation] = 1'b1;
                end
                m_loaded = (m_fill == 4'hF);
            end
        end else if (!m_pending) begin
            if (bus.gradeIt) begin
                m_guess   = bus.Guess;
                m_pending = 1;
            end
        end else if (bus.gradeAck) begin
            m_pending = 0;
            if (m_rounds < MAX_ROUNDS) m_rounds++;
            if (bus.numExact == 3'd4) begin
                m_won = 1; m_over = 1; m_ingame = 0;
            end else if (m_rounds == MAX_ROUNDS) begin
                m_won = 0; m_over = 1; m_ingame = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("pattern", 32'(bus.masterPattern), 32'(m_pattern()));
        chk("loaded",  32'(bus.masterLoaded),  32'(m_loaded));
        chk("req",     32'(bus.gradeReq),      32'(m_pending));
        chk("guess",   32'(bus.guessOut),      32'(m_guess));
        chk("round",   32'(bus.roundNumber),   32'(m_rounds));
        chk("over",    32'(bus.gameOver),      32'(m_over));
        chk("won",     32'(bus.gameWon),       32'(m_won));
        chk("loaderr", 32'(bus.loadError),     32'(m_err));
    endtask

    task automatic step();
        model_update();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic idle_in();
        bus.startGame = 1'b0; bus.loadingShape = 1'b0; bus.LoadShape = 3'd0; bus.ShapeLocation = 2'd0;
        bus.gradeIt = 1'b0; bus.Guess = 12'd0; bus.gradeAck = 1'b0; bus.numExact = 3'd0;
    endtask

    task automatic load(input logic [2:0] shape, input logic [1:0] slot);
        bus.loadingShape = 1'b1; bus.LoadShape = shape; bus.ShapeLocation = slot;
        step();
        bus.loadingShape = 1'b0;
    endtask

    task automatic start_game();
        bus.startGame = 1'b1;
        step();
        bus.startGame = 1'b0;
    endtask

    task automatic grade_round(input logic [2:0] exact, input int delay, input bit start_too);
        bus.gradeIt = 1'b1; bus.Guess = 12'($urandom);
        step();
        bus.gradeIt = 1'b0;
        for (int d = 0; d < delay; d++) step();
        bus.gradeAck = 1'b1; bus.numExact = exact; bus.startGame = start_too;
        step();
        bus.gradeAck = 1'b0; bus.startGame = 1'b0;
    endtask

    task automatic async_reset();
        #3;
        reset_L = 1'b0;
        #1;
        chk("rst_pattern", 32'(bus.masterPattern), 32'd0);
        chk("rst_loaded",  32'(bus.masterLoaded),  32'd0);
        chk("rst_req",     32'(bus.gradeReq),      32'd0);
        chk("rst_guess",   32'(bus.guessOut),      32'd0);
        chk("rst_round",   32'(bus.roundNumber),   32'd0);
        chk("rst_over",    32'(bus.gameOver),      32'd0);
        chk("rst_won",     32'(bus.gameWon),       32'd0);
        chk("rst_loaderr", 32'(bus.loadError),     32'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset_L = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  s0;
        logic        e3;
        int          req_cycles;
        s0 = OVERWRITE ? 3'd6 : 3'd1;
        e3 = OVERWRITE ? 1'b0 : 1'b1;

        vecs[0]  = mk(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 12'h000, 1'b0, 3'd0, 12'h000,                    1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 12'h000, 1'b0, 3'd0, 12'h000,                    1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 3'd1, 2'd0, 1'b0, 12'h000, 1'b0, 3'd0, {9'd0, 3'd1},               1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 3'd6, 2'd0, 1'b0, 12'h000, 1'b0, 3'd0, {9'd0, s0},                 1'b0, e3,   1'b0, 4'd0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 12'h000, 1'b0, 3'd0, {9'd0, s0},                 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 3'd2, 2'd1, 1'b0, 12'h000, 1'b0, 3'd0, {6'd0, 3'd2, s0},           1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 3'd3, 2'd2, 1'b0, 12'h000, 1'b0, 3'd0, {3'd0, 3'd3, 3'd2, s0},     1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 3'd4, 2'd3, 1'b0, 12'h000, 1'b0, 3'd0, {3'd4, 3'd3, 3'd2, s0},     1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 12'h0A5, 1'b0, 3'd0, {3'd4, 3'd3, 3'd2, s0},     1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 12'h777, 1'b0, 3'd0, {3'd4, 3'd3, 3'd2, s0},     1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 12'h000, 1'b0, 3'd0, {3'd4, 3'd3, 3'd2, s0},     1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 12'h000, 1'b0, 3'd0, {3'd4, 3'd3, 3'd2, s0},     1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 12'h000, 1'b1, 3'd2, {3'd4, 3'd3, 3'd2, s0},     1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
        vecs[13] = mk(1'b1, 1'b1, 3'd5, 2'd0, 1'b0, 12'h000, 1'b0, 3'd0, {3'd4, 3'd3, 3'd2, s0},     1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);

        // Power-on reset.
        idle_in();
        reset_L = 1'b0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        compare_all();
        reset_L = 1'b1;

        // Load, reject, overwrite and a stretched grade handshake from the vector table.
        req_cycles = 0;
        for (int i = 0; i < 14; i++) begin
            bus.startGame = vecs[i].st; bus.loadingShape = vecs[i].ld; bus.LoadShape = vecs[i].sh;
            bus.ShapeLocation = vecs[i].sl; bus.gradeIt = vecs[i].gr; bus.Guess = vecs[i].gu;
            bus.gradeAck = vecs[i].ak; bus.numExact = vecs[i].ex;
            step();
            chk($sformatf("vec%0d_pattern", i), 32'(bus.masterPattern), 32'(vecs[i].e_pat));
            chk($sformatf("vec%0d_loaded", i),  32'(bus.masterLoaded),  32'(vecs[i].e_loaded));
            chk($sformatf("vec%0d_loaderr", i), 32'(bus.loadError),     32'(vecs[i].e_err));
            chk($sformatf("vec%0d_req", i),     32'(bus.gradeReq),      32'(vecs[i].e_req));
            chk($sformatf("vec%0d_round", i),   32'(bus.roundNumber),   32'(vecs[i].e_round));
            chk($sformatf("vec%0d_over", i),    32'(bus.gameOver),      32'(vecs[i].e_over));
            chk($sformatf("vec%0d_won", i),     32'(bus.gameWon),       32'(vecs[i].e_won));
            if (bus.gradeReq) req_cycles++;
        end
        idle_in();
        chk("t4_req_cycles", 32'(req_cycles), 32'd4);
        chk("t4_guess_kept", 32'(bus.guessOut), 32'h0A5);

        // Lose after the round limit, then a late gradeIt must be ignored.
        for (int r = 0; r < 7; r++) grade_round(3'($urandom_range(0, 3)), $urandom_range(0, 3), 1'b0);
        chk("t5_over",  32'(bus.gameOver),    32'd1);
        chk("t5_won",   32'(bus.gameWon),     32'd0);
        chk("t5_round", 32'(bus.roundNumber), 32'd8);
        bus.gradeIt = 1'b1;
        step();
        bus.gradeIt = 1'b0;
        chk("t5_late_req", 32'(bus.gradeReq), 32'd0);

        // Win in round 3; round 2 carries a startGame alongside its ack.
        start_game();
        for (int s = 0; s < 4; s++) load(3'($urandom_range(1, 7)), 2'(s));
        grade_round(3'($urandom_range(0, 3)), 1, 1'b0);
        grade_round(3'd1, 0, 1'b1);
        chk("t6_start_ignored_round", 32'(bus.roundNumber), 32'd2);
        grade_round(3'd4, 2, 1'b0);
        chk("t6_over",  32'(bus.gameOver),    32'd1);
        chk("t6_won",   32'(bus.gameWon),     32'd1);
        chk("t6_round", 32'(bus.roundNumber), 32'd3);
        start_game();
        chk("t6_clr_round",   32'(bus.roundNumber),   32'd0);
        chk("t6_clr_over",    32'(bus.gameOver),      32'd0);
        chk("t6_clr_won",     32'(bus.gameWon),       32'd0);
        chk("t6_clr_loaded",  32'(bus.masterLoaded),  32'd0);
        chk("t6_clr_pattern", 32'(bus.masterPattern), 32'd0);

        // Asynchronous reset mid-LOAD, then the bitmap must be empty again.
        load(3'd5, 2'd0);
        load(3'd6, 2'd1);
        async_reset();
        start_game();
        load(3'd7, 2'd2);
        load(3'd7, 2'd0);
        chk("t1_slot0_empty", 32'(bus.loadError), 32'd0);
        load(3'd7, 2'd1);
        chk("t1_not_full", 32'(bus.masterLoaded), 32'd0);
        load(3'd7, 2'd3);
        chk("t1_full", 32'(bus.masterLoaded), 32'd1);

        // Asynchronous reset mid-GRADE with gradeAck pending.
        bus.gradeIt = 1'b1; bus.Guess = 12'hABC;
        step();
        bus.gradeIt = 1'b0;
        bus.gradeAck = 1'b1; bus.numExact = 3'd4;
        async_reset();
        step();
        chk("t1_ack_ignored_round", 32'(bus.roundNumber), 32'd0);
        chk("t1_ack_ignored_over",  32'(bus.gameOver),    32'd0);
        idle_in();

        // Random play against the model.
        for (int n = 0; n < 1500; n++) begin
            bus.startGame     = ($urandom_range(0, 19) == 0);
            bus.loadingShape  = 1'($urandom_range(0, 1));
            bus.LoadShape     = 3'($urandom_range(0, 7));
            bus.ShapeLocation = 2'($urandom_range(0, 3));
            bus.gradeIt       = ($urandom_range(0, 2) == 0);
            bus.Guess         = 12'($urandom);
            bus.gradeAck      = 1'($urandom_range(0, 1));
            bus.numExact      = ($urandom_range(0, 9) < 2) ? 3'd4 : 3'($urandom_range(0, 3));
            step();
        end
        idle_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
